// File: rtl/mem_responder_if.sv
// Loader and processor-side bus of the memory responder.
// Latency: none; this file only bundles the signals.
// Backpressure: load_ready qualifies load_valid; the processor ports have no handshake.
interface mem_responder_if #(
    parameter int WIDTH = 16
);
    // Loader stream
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] load_data;
    logic             load_last;

    // Processor control and status
    logic             run;
    logic [15:0]      load_count;
    logic             addr_err;

    // Instruction fetch port
    logic [15:0]      program_addr;
    logic [WIDTH-1:0] instr_data;

    // Data access port
    logic [15:0]      data_addr;
    logic [WIDTH-1:0] data_in;
    logic             mem_w;
    logic [WIDTH-1:0] mem_data;

    // Loader/processor side
    modport master (
        output load_valid, load_data, load_last,
        output program_addr, data_addr, data_in, mem_w,
        input  load_ready, run, load_count, addr_err,
        input  instr_data, mem_data
    );

    // Responder side
    modport slave (
        input  load_valid, load_data, load_last,
        input  program_addr, data_addr, data_in, mem_w,
        output load_ready, run, load_count, addr_err,
        output instr_data, mem_data
    );
endinterface

// File: rtl/mem_responder.sv
// Word memory that is first filled by a loader stream, then serves a processor's fetch and data ports.
// Latency: reads are combinational (zero cycles); writes and status updates land at the next rising clk edge.
// Backpressure: load_ready is high only in LOAD; beats offered in RUN are dropped. Optional MEM_WRITE_PROTECT_EN
// makes the loaded region read-only during RUN (stores below load_count are discarded and flag addr_err).
module mem_responder #(
    parameter int DEPTH = 1000,
    parameter int WIDTH = 16
) (
    input  logic           clk,
    input  logic           rst,
    mem_responder_if.slave bus
);

    // Index width of the storage array; addresses are range-checked before being narrowed to this.
    localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [15:0] LAST_IDX = 16'(DEPTH - 1);

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [15:0]      count_q;
    logic [15:0]      count_d;
    logic             err_q;
    logic             err_d;

    logic [WIDTH-1:0] mem [DEPTH];

    logic             prog_ok;
    logic             data_ok;
    logic             load_fire;
    logic             store_fire;
    logic             protect_hit;

    logic             wr_en;
    logic [AW-1:0]    wr_idx;
    logic [WIDTH-1:0] wr_dat;

    // True when a 16-bit address maps onto a stored word.
    function automatic logic in_range(input logic [15:0] a);
        return ({16'd0, a} < DEPTH);
    endfunction

    assign prog_ok = in_range(bus.program_addr);
    assign data_ok = in_range(bus.data_addr);

`ifdef MEM_WRITE_PROTECT_EN
    // Stores into the loaded image are refused once the processor is running.
    assign protect_hit = (state_q == RUN) && bus.mem_w && data_ok && (bus.data_addr < count_q);
`else
    assign protect_hit = 1'b0;
`endif

    // Zero-latency read ports; out-of-range addresses read as zero.
    always_comb begin
        bus.instr_data = '0;
        bus.mem_data   = '0;
        if (prog_ok) begin
            bus.instr_data = mem[bus.program_addr[AW-1:0]];
        end
        if (data_ok) begin
            bus.mem_data = mem[bus.data_addr[AW-1:0]];
        end
    end

    // Next-state, counters, error flag and the state-decoded outputs.
    always_comb begin
        state_d        = state_q;
        count_d        = count_q;
        err_d          = err_q;
        load_fire      = 1'b0;
        store_fire     = 1'b0;
        bus.load_ready = 1'b0;
        bus.run        = 1'b0;
        case (state_q)
            LOAD: begin
                bus.load_ready = 1'b1;
                if (bus.load_valid) begin
                    load_fire = 1'b1;
                    count_d   = count_q + 16'd1;
                    // The final array slot ends loading even without load_last.
                    if (bus.load_last || (count_q == LAST_IDX)) begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                bus.run = 1'b1;
                if (bus.mem_w && data_ok && !protect_hit) begin
                    store_fire = 1'b1;
                end
                // The data port reads every cycle, so a bad data_addr counts with or without mem_w.
                if (!prog_ok || !data_ok || protect_hit) begin
                    err_d = 1'b1;
                end
            end
            default: begin
                state_d = LOAD;
            end
        endcase
    end

    // Single write port shared by the loader (LOAD) and processor stores (RUN); reset suppresses both.
    always_comb begin
        wr_en  = 1'b0;
        wr_idx = '0;
        wr_dat = '0;
        if (!rst) begin
            if (load_fire) begin
                wr_en  = 1'b1;
                wr_idx = count_q[AW-1:0];
                wr_dat = bus.load_data;
            end else if (store_fire) begin
                wr_en  = 1'b1;
                wr_idx = bus.data_addr[AW-1:0];
                wr_dat = bus.data_in;
            end
        end
    end

    // Storage array; deliberately not reset so the image survives a processor restart.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_dat;
        end
    end

    // State, load counter and sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LOAD;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    assign bus.load_count = count_q;
    assign bus.addr_err   = err_q;

endmodule
